// File: rtl/video_measure_if.sv
// Tap bundle for video_measure: sampled raster timing/video from the
// upstream test stage and the measurement results.
interface video_measure_if;
    logic        cen_i;
    logic [3:0]  fvht_i;
    logic [19:0] video_i;
    logic [15:0] tot_len_o;
    logic [15:0] act_len_o;
    logic [15:0] act_lines_o;
    logic        field_o;
    logic        frame_o;
    logic        locked_o;
    logic        err_o;
    logic [23:0] checksum_o;

    modport master (
        output cen_i, fvht_i, video_i,
        input  tot_len_o, act_len_o, act_lines_o, field_o, frame_o,
               locked_o, err_o, checksum_o
    );

    modport slave (
        input  cen_i, fvht_i, video_i,
        output tot_len_o, act_len_o, act_lines_o, field_o, frame_o,
               locked_o, err_o, checksum_o
    );
endinterface

// File: rtl/video_measure.sv
// Passive raster analyser: per frame it measures samples per line, active
// samples in the first active line and the active line count, then runs a
// lock state machine over consecutive frames. Never touches the video path.
// Optional active-luma checksum: define VIDEO_MEASURE_CHECKSUM_EN.
module video_measure #(
    parameter int unsigned LOCK_FRAMES = 3,
    parameter int unsigned TIMEOUT_CYC = 4000000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    video_measure_if.slave bus
);
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

    logic        h, v, h_q, v_q;
    logic        h_fall, h_rise, v_rise;
    logic        line_close, frame_end, to_expire;
    logic [15:0] tot_cnt, tot_m, act_cnt, act_ref, line_cnt;
    logic        frame_err, primed;
    logic [15:0] lines_fin, act_ref_fin;
    logic        err_fin, same;
    logic [15:0] ref_tot, ref_act, ref_lines;
    logic [3:0]  match;
    logic [1:0]  state;
    logic [31:0] to_cnt;
    logic [15:0] tot_pub, act_pub, lines_pub;
    logic        field_pub, frame_q, err_q;

    assign h          = bus.fvht_i[1];
    assign v          = bus.fvht_i[2];
    assign h_fall     = h_q & ~h;
    assign h_rise     = ~h_q & h;
    assign v_rise     = ~v_q & v;
    // Previous V qualifies the line, so a line ending on the V-rise sample counts.
    assign line_close = bus.cen_i & h_rise & ~v_q;
    assign frame_end  = bus.cen_i & v_rise;
    assign to_expire  = ~frame_end & (to_cnt == TIMEOUT_CYC - 1);

    // Frame totals including a line that closes on this very sample.
    always_comb begin
        lines_fin   = line_cnt;
        act_ref_fin = act_ref;
        err_fin     = frame_err;
        if (line_close) begin
            lines_fin = line_cnt + 16'd1;
            if (line_cnt == '0)
                act_ref_fin = act_cnt;
            else if (act_cnt != act_ref)
                err_fin = 1'b1;
        end
    end

    assign same = (tot_m == ref_tot) && (act_ref_fin == ref_act) && (lines_fin == ref_lines);

    // Sample history plus line-period and active-width counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h_q     <= 1'b1;
            v_q     <= 1'b1;
            tot_cnt <= '0;
            tot_m   <= '0;
            act_cnt <= '0;
        end else if (bus.cen_i) begin
            h_q <= h;
            v_q <= v;
            if (h_fall) begin
                tot_m   <= tot_cnt;
                tot_cnt <= 16'd1;
                act_cnt <= 16'd1;
            end else begin
                if (tot_cnt != '1)
                    tot_cnt <= tot_cnt + 16'd1;
                if (!h && act_cnt != '1)
                    act_cnt <= act_cnt + 16'd1;
            end
        end
    end

    // Active line count, first-line width reference and width-consistency error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_cnt  <= '0;
            act_ref   <= '0;
            frame_err <= 1'b0;
        end else if (frame_end) begin
            line_cnt  <= '0;
            frame_err <= 1'b0;
        end else if (line_close) begin
            line_cnt  <= lines_fin;
            act_ref   <= act_ref_fin;
            frame_err <= err_fin;
        end
    end

    // Frame-end watchdog; runs every clk, restarts on frame end or expiry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            to_cnt <= '0;
        else if (frame_end || to_expire)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 32'd1;
    end

    // Publish measurements and step the lock state machine at each frame end.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            primed    <= 1'b0;
            tot_pub   <= '0;
            act_pub   <= '0;
            lines_pub <= '0;
            field_pub <= 1'b0;
            frame_q   <= 1'b0;
            err_q     <= 1'b0;
            state     <= SEARCH;
            match     <= '0;
            ref_tot   <= '0;
            ref_act   <= '0;
            ref_lines <= '0;
        end else begin
            frame_q <= 1'b0;
            err_q   <= 1'b0;
            if (frame_end) begin
                if (!primed) begin
                    primed <= 1'b1;
                end else begin
                    tot_pub   <= tot_m;
                    act_pub   <= act_ref_fin;
                    lines_pub <= lines_fin;
                    field_pub <= bus.fvht_i[3];
                    frame_q   <= 1'b1;
                    case (state)
                        SEARCH: begin
                            if (!err_fin) begin
                                ref_tot   <= tot_m;
                                ref_act   <= act_ref_fin;
                                ref_lines <= lines_fin;
                                match     <= 4'd1;
                                state     <= CHECK;
                            end
                        end
                        CHECK: begin
                            if (err_fin) begin
                                state <= SEARCH;
                            end else if (same) begin
                                match <= match + 4'd1;
                                if (match + 4'd1 == LOCK_N)
                                    state <= LOCKED;
                            end else begin
                                ref_tot   <= tot_m;
                                ref_act   <= act_ref_fin;
                                ref_lines <= lines_fin;
                                match     <= 4'd1;
                            end
                        end
                        LOCKED: begin
                            if (err_fin || !same) begin
                                state <= SEARCH;
                                err_q <= 1'b1;
                            end
                        end
                        default: state <= SEARCH;
                    endcase
                end
            end else if (to_expire) begin
                state <= SEARCH;
                err_q <= (state == LOCKED);
            end
        end
    end

    assign bus.tot_len_o   = tot_pub;
    assign bus.act_len_o   = act_pub;
    assign bus.act_lines_o = lines_pub;
    assign bus.field_o     = field_pub;
    assign bus.frame_o     = frame_q;
    assign bus.locked_o    = (state == LOCKED);
    assign bus.err_o       = err_q;

`ifdef VIDEO_MEASURE_CHECKSUM_EN
    logic [23:0] chk_acc, chk_pub;
    logic        unused_bits;
    assign unused_bits = ^{bus.fvht_i[0], bus.video_i[9:0]};

    // Accumulate luma over the active picture; restart at each frame end.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            chk_acc <= '0;
        else if (frame_end)
            chk_acc <= '0;
        else if (bus.cen_i && !h && !v)
            chk_acc <= chk_acc + {14'd0, bus.video_i[19:10]};
    end

    // Publish the checksum alongside the other measurements.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            chk_pub <= '0;
        else if (frame_end && primed)
            chk_pub <= chk_acc;
    end

    assign bus.checksum_o = chk_pub;
`else
    logic unused_bits;
    assign unused_bits    = ^{bus.fvht_i[0], bus.video_i};
    assign bus.checksum_o = '0;
`endif
endmodule
